env_update_sched: RTL
=====================

Name: env_update_sched

Overview:
Read-modify-write scheduler for the environment row array. It shares the single lookup port and single write port of the environment between N_ANTS pheromone-deposit requesters and a global evaporation (decay) sweep. It is placed between the ant modules and the environment module; it drives the lookup address, lookup_data returns combinationally, and it issues the write-back.

Parameters:
N_ANTS, 4, number of ant requesters
X_bits, 8, column address width (PIXELS_X columns)
Y_bits, 8, row address width (PIXELS_Y rows)
PIXELS_X, 160, columns; valid x is 0..PIXELS_X-1
PIXELS_Y, 120, rows; valid y is 0..PIXELS_Y-1
SIGNAL_bits, 7, pheromone signal width
DECAY_AMT, 1, amount subtracted from each cell per sweep

Ports:
newLocClock  in  1  sole clock, rising edge
RESET_SIM_N  in  1  asynchronous active-low reset
req_valid  in  N_ANTS  deposit request, one bit per ant
req_x  in  N_ANTS*X_bits  target column per ant
req_y  in  N_ANTS*Y_bits  target row per ant
req_amt  in  N_ANTS*SIGNAL_bits  deposit amount per ant
req_take_sugar  in  N_ANTS  clears the sugar bit at the target cell
req_ready  out  N_ANTS  one-hot grant; the request fields are sampled in this cycle
decay_start  in  1  pulse that starts a full-array decay sweep
decay_busy  out  1  sweep in progress
decay_done  out  1  one-cycle pulse after the last cell is written
lookup_X  out  X_bits  lookup column to the environment
lookup_Y  out  Y_bits  lookup row to the environment
lookup_data  in  SIGNAL_bits+1  {signal,sugar}; sugar is the LSB; combinational from lookup_X/Y
write_X  out  X_bits  write column
write_Y  out  Y_bits  write row (decoded to per-row write flags downstream)
write_en  out  1  write strobe
write_signal  out  SIGNAL_bits  new signal value
write_sugar  out  1  new sugar bit

Behaviour:
- FSM states: IDLE, ANT_RD, ANT_WR, DEC_RD, DEC_WR. Every operation takes exactly 2 cycles: RD then WR.
- RD cycle: drive lookup_X/Y from the captured address, register lookup_data at the end of the cycle.
- WR cycle: write_en=1 with the computed value. write_X/Y equal the captured address.
- Scheduling decisions are made in IDLE and in the WR cycle, so back-to-back operations sustain 1 op per 2 cycles.
- Decision rule:
  - If any req_valid is high and no decay is pending, pick an ant.
  - If only decay is pending, go to DEC_RD.
  - If both are pending, alternate: after an ant op take a decay cell, after a decay cell take an ant. From IDLE, the ant goes first.
  - If nothing is pending, go to IDLE.
- Ant arbitration is round-robin. Search starts at rr_ptr; the granted index is i, and rr_ptr becomes (i+1) mod N_ANTS.
- req_ready[i] is high combinationally for one cycle, the decision cycle that enters ANT_RD. req_x/y/amt/take_sugar[i] are captured on that edge.
- A requester holds its fields stable while valid is high and ready is low. A requester that keeps valid high after ready is treated as a new request.
- Ant write value:
  - signal = min(sig + amt, 2^SIGNAL_bits - 1), computed at SIGNAL_bits+1 width, then saturated.
  - sugar = take_sugar ? 0 : old sugar.
- Decay write value: signal = (sig >= DECAY_AMT) ? sig - DECAY_AMT : 0. Sugar is unchanged.
- Out-of-range ant address (x >= PIXELS_X or y >= PIXELS_Y): the request is still granted and consumes both cycles, but write_en stays 0.
- Decay sweep:
  - decay_start while idle sets decay_busy=1 on the next edge and resets the cursor to (0,0).
  - The cursor advances x first, then y. After cell (PIXELS_X-1, PIXELS_Y-1) is written, busy clears and decay_done pulses for 1 cycle on the following cycle.
  - decay_start while busy is ignored.
  - The sweep touches exactly PIXELS_X*PIXELS_Y cells.
- Same-cell hazard: none possible, because operations are strictly serialized and the write lands before the next RD.
- Reset (asynchronous, any state): state=IDLE, rr_ptr=0, decay_busy=0, decay_done=0, write_en=0, req_ready=0, and all address/data outputs 0. Any in-flight op is dropped with no partial write.

Test Plan:
- Single deposit: cell (3,5)={10,1}; ant1 valid, amt=20, take_sugar=1 -> req_ready[1] pulses once; 2 cycles later write_en=1 at (3,5), signal=30, sugar=0.
- Saturation: cell={120,0}, amt=20 -> write_signal=127. Second case: cell={0,0}, decay with DECAY_AMT=1 -> write_signal=0.
- Round-robin: all 4 ants continuously valid -> grants 0,1,2,3,0,1 on decision cycles spaced 2 cycles apart; no ant is granted twice before the others.
- Decay with contention: ant0 held valid and decay_start pulsed -> ops alternate ANT, DEC, ANT, DEC; decay_done fires after exactly 160*120 decay writes; every cell written with signal-1.
- Out-of-range and ignored start: req_x=200 -> req_ready pulses, no write_en. decay_start during a sweep -> no cursor reset, single decay_done.
- Reset mid-op: assert RESET_SIM_N=0 during ANT_WR -> write_en drops immediately without waiting for a clock. After release: IDLE, decay_busy=0, and the next grant goes to ant0.

Source files
------------

// File: rtl/env_update_sched_if.sv
// Bundle of the ant request, decay control, environment lookup and write-back
// signals. The scheduler attaches through the slave modport.
interface env_update_sched_if #(
    parameter int N_ANTS      = 4,
    parameter int X_bits      = 8,
    parameter int Y_bits      = 8,
    parameter int SIGNAL_bits = 7
);
    logic [N_ANTS-1:0]             req_valid;
    logic [N_ANTS*X_bits-1:0]      req_x;
    logic [N_ANTS*Y_bits-1:0]      req_y;
    logic [N_ANTS*SIGNAL_bits-1:0] req_amt;
    logic [N_ANTS-1:0]             req_take_sugar;
    logic [N_ANTS-1:0]             req_ready;
    logic                          decay_start;
    logic                          decay_busy;
    logic                          decay_done;
    logic [X_bits-1:0]             lookup_X;
    logic [Y_bits-1:0]             lookup_Y;
    logic [SIGNAL_bits:0]          lookup_data;
    logic [X_bits-1:0]             write_X;
    logic [Y_bits-1:0]             write_Y;
    logic                          write_en;
    logic [SIGNAL_bits-1:0]        write_signal;
    logic                          write_sugar;

    modport master (
        output req_valid, req_x, req_y, req_amt, req_take_sugar, decay_start, lookup_data,
        input  req_ready, decay_busy, decay_done, lookup_X, lookup_Y,
               write_X, write_Y, write_en, write_signal, write_sugar
    );

    modport slave (
        input  req_valid, req_x, req_y, req_amt, req_take_sugar, decay_start, lookup_data,
        output req_ready, decay_busy, decay_done, lookup_X, lookup_Y,
               write_X, write_Y, write_en, write_signal, write_sugar
    );
endinterface

// File: rtl/env_update_sched.sv
// Read-modify-write scheduler sharing the environment lookup/write ports between
// round-robin ant pheromone deposits and a full-array evaporation sweep.
module env_update_sched #(
    parameter int N_ANTS      = 4,
    parameter int X_bits      = 8,
    parameter int Y_bits      = 8,
    parameter int PIXELS_X    = 160,
    parameter int PIXELS_Y    = 120,
    parameter int SIGNAL_bits = 7,
    parameter int DECAY_AMT   = 1
) (
    input logic               newLocClock,
    input logic               RESET_SIM_N,
    env_update_sched_if.slave bus
);
    localparam int PTR_W = (N_ANTS > 1) ? $clog2(N_ANTS) : 1;
    localparam logic [SIGNAL_bits-1:0] SIG_MAX = '1;
    localparam logic [SIGNAL_bits-1:0] DEC_AMT = SIGNAL_bits'(DECAY_AMT);
    localparam logic [X_bits-1:0] LAST_X = X_bits'(PIXELS_X - 1);
    localparam logic [Y_bits-1:0] LAST_Y = Y_bits'(PIXELS_Y - 1);
    localparam logic [X_bits:0] X_LIM = (X_bits + 1)'(PIXELS_X);
    localparam logic [Y_bits:0] Y_LIM = (Y_bits + 1)'(PIXELS_Y);

    typedef enum logic [2:0] {IDLE, ANT_RD, ANT_WR, DEC_RD, DEC_WR} state_t;

    state_t                 state_q, state_d;
    logic [PTR_W-1:0]       rrPtr_q, rrPtr_d;
    logic [X_bits-1:0]      addrX_q, addrX_d;
    logic [Y_bits-1:0]      addrY_q, addrY_d;
    logic [SIGNAL_bits-1:0] amt_q, amt_d;
    logic                   takeSugar_q, takeSugar_d;
    logic                   inRange_q, inRange_d;
    logic [SIGNAL_bits:0]   data_q, data_d;
    logic                   decayBusy_q, decayBusy_d;
    logic                   decayDone_q, decayDone_d;
    logic [X_bits-1:0]      curX_q, curX_d;
    logic [Y_bits-1:0]      curY_q, curY_d;

    logic [PTR_W-1:0]       cand, grantIdx;
    logic                   antFound, decPending, lastCell, takeAnt, takeDec;
    logic [N_ANTS-1:0]      readyVec;
    logic [X_bits-1:0]      selX;
    logic [Y_bits-1:0]      selY;
    logic [SIGNAL_bits:0]   antSum;
    logic [SIGNAL_bits-1:0] oldSig, antSig, decSig;

    // First valid requester at or after rrPtr_q, wrapping modulo N_ANTS.
    always_comb begin
        antFound = 1'b0;
        grantIdx = '0;
        cand     = '0;
        for (int k = 0; k < N_ANTS; k++) begin
            cand = PTR_W'((int'(rrPtr_q) + k) % N_ANTS);
            if (!antFound && bus.req_valid[cand]) begin
                antFound = 1'b1;
                grantIdx = cand;
            end
        end
    end

    assign selX = bus.req_x[int'(grantIdx)*X_bits +: X_bits];
    assign selY = bus.req_y[int'(grantIdx)*Y_bits +: Y_bits];

    // The last cell's write retires the sweep, so it no longer competes for the next slot.
    assign lastCell   = (curX_q == LAST_X) && (curY_q == LAST_Y);
    assign decPending = decayBusy_q && !((state_q == DEC_WR) && lastCell);
    assign takeAnt    = antFound && (!decPending || (state_q != ANT_WR));
    assign takeDec    = decPending && !takeAnt;

    always_comb begin
        state_d     = state_q;
        rrPtr_d     = rrPtr_q;
        addrX_d     = addrX_q;
        addrY_d     = addrY_q;
        amt_d       = amt_q;
        takeSugar_d = takeSugar_q;
        inRange_d   = inRange_q;
        data_d      = data_q;
        decayBusy_d = decayBusy_q;
        decayDone_d = 1'b0;
        curX_d      = curX_q;
        curY_d      = curY_q;
        readyVec    = '0;

        if (bus.decay_start && !decayBusy_q) begin
            decayBusy_d = 1'b1;
            curX_d      = '0;
            curY_d      = '0;
        end

        case (state_q)
            ANT_RD: begin
                data_d  = bus.lookup_data;
                state_d = ANT_WR;
            end
            DEC_RD: begin
                data_d  = bus.lookup_data;
                state_d = DEC_WR;
            end
            default: begin
                if (state_q == DEC_WR) begin
                    if (lastCell) begin
                        curX_d      = '0;
                        curY_d      = '0;
                        decayBusy_d = 1'b0;
                        decayDone_d = 1'b1;
                    end else if (curX_q == LAST_X) begin
                        curX_d = '0;
                        curY_d = curY_q + 1'b1;
                    end else begin
                        curX_d = curX_q + 1'b1;
                    end
                end

                if (takeAnt) begin
                    readyVec[grantIdx] = 1'b1;
                    rrPtr_d     = PTR_W'((int'(grantIdx) + 1) % N_ANTS);
                    addrX_d     = selX;
                    addrY_d     = selY;
                    amt_d       = bus.req_amt[int'(grantIdx)*SIGNAL_bits +: SIGNAL_bits];
                    takeSugar_d = bus.req_take_sugar[grantIdx];
                    inRange_d   = ({1'b0, selX} < X_LIM) && ({1'b0, selY} < Y_LIM);
                    state_d     = ANT_RD;
                end else if (takeDec) begin
                    addrX_d   = curX_d;
                    addrY_d   = curY_d;
                    inRange_d = 1'b1;
                    state_d   = DEC_RD;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge newLocClock or negedge RESET_SIM_N) begin
        if (!RESET_SIM_N) begin
            state_q     <= IDLE;
            rrPtr_q     <= '0;
            addrX_q     <= '0;
            addrY_q     <= '0;
            amt_q       <= '0;
            takeSugar_q <= 1'b0;
            inRange_q   <= 1'b0;
            data_q      <= '0;
            decayBusy_q <= 1'b0;
            decayDone_q <= 1'b0;
            curX_q      <= '0;
            curY_q      <= '0;
        end else begin
            state_q     <= state_d;
            rrPtr_q     <= rrPtr_d;
            addrX_q     <= addrX_d;
            addrY_q     <= addrY_d;
            amt_q       <= amt_d;
            takeSugar_q <= takeSugar_d;
            inRange_q   <= inRange_d;
            data_q      <= data_d;
            decayBusy_q <= decayBusy_d;
            decayDone_q <= decayDone_d;
            curX_q      <= curX_d;
            curY_q      <= curY_d;
        end
    end

    // Deposit sums one bit wider so the carry-out drives saturation.
    assign oldSig = data_q[SIGNAL_bits:1];
    assign antSum = {1'b0, oldSig} + {1'b0, amt_q};
    assign antSig = antSum[SIGNAL_bits] ? SIG_MAX : antSum[SIGNAL_bits-1:0];
    assign decSig = (oldSig >= DEC_AMT) ? (oldSig - DEC_AMT) : '0;

    assign bus.req_ready    = readyVec;
    assign bus.decay_busy   = decayBusy_q;
    assign bus.decay_done   = decayDone_q;
    assign bus.lookup_X     = addrX_q;
    assign bus.lookup_Y     = addrY_q;
    assign bus.write_X      = addrX_q;
    assign bus.write_Y      = addrY_q;
    assign bus.write_en     = ((state_q == ANT_WR) && inRange_q) || (state_q == DEC_WR);
    assign bus.write_signal = (state_q == ANT_WR) ? antSig :
                              (state_q == DEC_WR) ? decSig : '0;
    assign bus.write_sugar  = (state_q == ANT_WR) ? (!takeSugar_q && data_q[0]) :
                              (state_q == DEC_WR) ? data_q[0] : 1'b0;
endmodule
